vga_bouncing_box: RTL and testbench
===================================

VGA_BOUNCING_BOX -- requirements
Module: vga_bouncing_box

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE, 640, visible pixels per line; V_ACTIVE, 480, visible lines; BOX_SIZE, 32, box edge in pixels; INIT_X, 100, reset box left edge; INIT_Y, 100, reset box top edge.
REQ-002 Ports SHALL be (name, direction, width, meaning): CLK_50 in 1, sole clock, rising edge; RST_N in 1, synchronous active-low reset.
REQ-003 counter_x in 10, current pixel column from sync generator; counter_y in 10, current line.
REQ-004 in_display_area in 1, high when (counter_x, counter_y) is visible; h_sync_in in 1 and v_sync_in in 1, raw syncs.
REQ-005 speed in 4, pixels moved per frame on each axis; pause in 1, high freezes motion.
REQ-006 RED out 3, GREEN out 3, BLUE out 2, registered pixel colour; h_sync out 1 and v_sync out 1, delayed syncs.
REQ-007 frame_tick out 1, one-cycle pulse per frame; bounce out 1, one-cycle pulse when any wall is hit.

Function
REQ-008 RED/GREEN/BLUE, h_sync, v_sync SHALL all have exactly 1 CLK_50 cycle of latency from the inputs, keeping colour aligned with syncs.
REQ-009 Pixel is "in box" iff box_x <= counter_x < box_x+BOX_SIZE and box_y <= counter_y < box_y+BOX_SIZE, with inclusive left/top and exclusive right/bottom bounds.
REQ-010 In box and in_display_area: colour 111/111/11 (white); in display, not in box: 000/000/01 (dark blue); in_display_area low: 000/000/00.
REQ-011 frame_tick SHALL pulse for one cycle on the first cycle where (counter_y == V_ACTIVE) becomes true after having been false; multi-cycle dwell of counter values SHALL yield one pulse only.
REQ-012 Position registers box_x, box_y are 10 bits; range 0..H_ACTIVE-BOX_SIZE and 0..V_ACTIVE-BOX_SIZE; arithmetic SHALL be done in 11 bits so no wrap-around occurs.
REQ-013 Direction FSM: states RIGHT_DOWN, RIGHT_UP, LEFT_DOWN, LEFT_UP; updated only on frame_tick with pause low.
REQ-014 X moving right: if box_x+speed >= H_ACTIVE-BOX_SIZE then box_x = H_ACTIVE-BOX_SIZE and direction flips to left, else box_x += speed.
REQ-015 X moving left: if box_x <= speed then box_x = 0 and direction flips to right, else box_x -= speed; Y axis identical with V_ACTIVE.
REQ-016 speed == 0 SHALL cause no movement and no direction change, even when resting at a wall.
REQ-017 Corner hit: both axes SHALL flip in the same frame_tick; bounce pulses once.
REQ-018 bounce SHALL pulse on the cycle after the frame_tick that caused any flip.
REQ-019 pause high on the frame_tick cycle: no position/direction change, no bounce; frame_tick still pulses.
REQ-020 speed SHALL be sampled only on the frame_tick cycle; position changes are visible from the next cycle (mid-frame tearing impossible since tick occurs outside the active area).

Reset
REQ-021 With RST_N low at a rising edge: RGB = 0, h_sync = 1, v_sync = 1, frame_tick = 0, bounce = 0, box_x = INIT_X, box_y = INIT_Y, state RIGHT_DOWN, edge-detect history cleared, flash counter 0.
REQ-022 Reset asserted mid-frame SHALL take effect at the next edge; the first frame_tick after release requires a fresh false-to-true transition.

Configuration
REQ-023 Macro BOUNCE_FLASH_EN: when defined, each bounce loads a 3-bit counter with 7, decremented per frame_tick to 0; while nonzero box colour is 111/000/00 (red). When undefined, no counter exists and the box is always white.

Verification
REQ-024 Reset, speed=2, pause=0, one frame -> box_x=102, box_y=102, state RIGHT_DOWN, bounce never pulses.
REQ-025 Preload box_x=606 (H_ACTIVE-BOX_SIZE-2), speed=5, moving right -> box_x=608, state LEFT_*, bounce pulses once; next frame box_x=603.
REQ-026 box_x=3, box_y=2, LEFT_UP, speed=4 -> box_x=0, box_y=0, RIGHT_DOWN, single bounce pulse.
REQ-027 Box at (100,100): counter (99,100) -> dark blue, (100,100) -> white, (131,131) -> white, (132,100) -> dark blue, in_display_area=0 -> black; each exactly 1 cycle after input, syncs equally delayed.
REQ-028 pause=1 over 3 frames -> 3 frame_tick pulses, position unchanged; counter_y held at V_ACTIVE for 5 cycles -> one frame_tick.
REQ-029 BOUNCE_FLASH_EN defined: after bounce box is red for 7 frames, white on the 8th; undefined: always white.

Source files
------------

// File: rtl/vga_bouncing_box.sv
// Bouncing box overlay for a VGA timing chain: moves a square once per frame and
// paints it over the active area. Optional build macro BOUNCE_FLASH_EN flashes the box red after a bounce.
module vga_bouncing_box #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 100
) (
  input  logic       CLK_50,
  input  logic       RST_N,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       in_display_area,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic [3:0] speed,
  input  logic       pause,
  output logic [2:0] RED,
  output logic [2:0] GREEN,
  output logic [1:0] BLUE,
  output logic       h_sync,
  output logic       v_sync,
  output logic       frame_tick,
  output logic       bounce
);

  typedef enum logic [1:0] {
    RIGHT_DOWN = 2'b00,
    RIGHT_UP   = 2'b01,
    LEFT_DOWN  = 2'b10,
    LEFT_UP    = 2'b11
  } dir_t;

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] BOX_W = 11'(BOX_SIZE);
  localparam logic [9:0]  V_END = 10'(V_ACTIVE);

  localparam logic [7:0] COL_BLACK = 8'b000_000_00;
  localparam logic [7:0] COL_BLUE  = 8'b000_000_01;
  localparam logic [7:0] COL_WHITE = 8'b111_111_11;

  dir_t        state;
  dir_t        state_next;
  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic        tick_armed;
  logic        at_v_end;
  logic        moving_left;
  logic        moving_up;
  logic        move_en;
  logic        flip_x;
  logic        flip_y;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic [10:0] sp;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] cx;
  logic [10:0] cy;
  logic        in_box;
  logic [7:0]  box_colour;

  assign at_v_end = (counter_y == V_END);

  // tick_armed is set only after counter_y has been seen away from V_ACTIVE, so a
  // long dwell, or a reset released while sitting on V_ACTIVE, cannot fire a tick.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      tick_armed <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= at_v_end && tick_armed;
      tick_armed <= !at_v_end;
    end
  end

  assign sp      = {7'd0, speed};
  assign x_ext   = {1'b0, box_x};
  assign y_ext   = {1'b0, box_y};
  assign move_en = frame_tick && !pause && (speed != 4'd0);

  // NOTE: every output of a combinational block gets a default first, otherwise
  // a path that skips an assignment infers a latch.
  always_comb begin
    moving_left = 1'b0;
    moving_up   = 1'b0;
    case (state)
      RIGHT_UP:  moving_up   = 1'b1;
      LEFT_DOWN: moving_left = 1'b1;
      LEFT_UP: begin
        moving_left = 1'b1;
        moving_up   = 1'b1;
      end
      default: ;
    endcase

    flip_x = 1'b0;
    x_next = box_x;
    if (!moving_left) begin
      if (x_ext + sp >= X_MAX) begin
        x_next = 10'(X_MAX);
        flip_x = 1'b1;
      end else begin
        x_next = 10'(x_ext + sp);
      end
    end else if (x_ext <= sp) begin
      x_next = 10'd0;
      flip_x = 1'b1;
    end else begin
      x_next = 10'(x_ext - sp);
    end

    flip_y = 1'b0;
    y_next = box_y;
    if (!moving_up) begin
      if (y_ext + sp >= Y_MAX) begin
        y_next = 10'(Y_MAX);
        flip_y = 1'b1;
      end else begin
        y_next = 10'(y_ext + sp);
      end
    end else if (y_ext <= sp) begin
      y_next = 10'd0;
      flip_y = 1'b1;
    end else begin
      y_next = 10'(y_ext - sp);
    end

    case ({moving_left ^ flip_x, moving_up ^ flip_y})
      2'b00:   state_next = RIGHT_DOWN;
      2'b01:   state_next = RIGHT_UP;
      2'b10:   state_next = LEFT_DOWN;
      default: state_next = LEFT_UP;
    endcase
  end

  // NOTE: reset is synchronous: it is sampled like any other input at the clock edge.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      state  <= RIGHT_DOWN;
      box_x  <= 10'(INIT_X);
      box_y  <= 10'(INIT_Y);
      bounce <= 1'b0;
    end else begin
      bounce <= move_en && (flip_x || flip_y);
      if (move_en) begin
        box_x <= x_next;
        box_y <= y_next;
        state <= state_next;
      end
    end
  end

`ifdef BOUNCE_FLASH_EN
  logic [2:0] flash_cnt;

  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      flash_cnt <= 3'd0;
    end else if (move_en && (flip_x || flip_y)) begin
      flash_cnt <= 3'd7;
    end else if (frame_tick && (flash_cnt != 3'd0)) begin
      flash_cnt <= flash_cnt - 3'd1;
    end
  end

  assign box_colour = (flash_cnt != 3'd0) ? 8'b111_000_00 : COL_WHITE;
`else
  assign box_colour = COL_WHITE;
`endif

  // Right and bottom edges are exclusive; 11-bit sums keep box_x+BOX_SIZE from wrapping.
  assign cx     = {1'b0, counter_x};
  assign cy     = {1'b0, counter_y};
  assign in_box = (cx >= x_ext) && (cx < x_ext + BOX_W) &&
                  (cy >= y_ext) && (cy < y_ext + BOX_W);

  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      {RED, GREEN, BLUE} <= COL_BLACK;
      h_sync             <= 1'b1;
      v_sync             <= 1'b1;
    end else begin
      h_sync <= h_sync_in;
      v_sync <= v_sync_in;
      if (!in_display_area)
        {RED, GREEN, BLUE} <= COL_BLACK;
      else if (in_box)
        {RED, GREEN, BLUE} <= box_colour;
      else
        {RED, GREEN, BLUE} <= COL_BLUE;
    end
  end

endmodule

// File: tb/tb_vga_bouncing_box.sv
// Directed bench for vga_bouncing_box: three instances share stimulus so the wall
// and corner cases start from reset positions instead of long approach runs.
module tb_vga_bouncing_box;

  logic       CLK_50 = 1'b0;
  logic       RST_N  = 1'b0;
  logic [9:0] counter_x = '0;
  logic [9:0] counter_y = '0;
  logic       in_display_area = 1'b0;
  logic       h_sync_in = 1'b1;
  logic       v_sync_in = 1'b1;
  logic [3:0] speed = '0;
  logic       pause = 1'b0;

  logic [2:0] red_a, green_a, red_b, green_b, red_c, green_c;
  logic [1:0] blue_a, blue_b, blue_c;
  logic       hs_a, vs_a, ft_a, bn_a;
  logic       hs_b, vs_b, ft_b, bn_b;
  logic       hs_c, vs_c, ft_c, bn_c;

  int tests_run = 0;
  int tests_failed = 0;
  int ticks = 0;
  int bc_a = 0;
  int bc_b = 0;
  int bc_c = 0;

  always #10 CLK_50 = ~CLK_50;

  vga_bouncing_box dut (
    .CLK_50(CLK_50), .RST_N(RST_N), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .speed(speed), .pause(pause), .RED(red_a), .GREEN(green_a), .BLUE(blue_a),
    .h_sync(hs_a), .v_sync(vs_a), .frame_tick(ft_a), .bounce(bn_a)
  );

  vga_bouncing_box #(.INIT_X(606), .INIT_Y(100)) dut_b (
    .CLK_50(CLK_50), .RST_N(RST_N), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .speed(speed), .pause(pause), .RED(red_b), .GREEN(green_b), .BLUE(blue_b),
    .h_sync(hs_b), .v_sync(vs_b), .frame_tick(ft_b), .bounce(bn_b)
  );

  // x range 0..449, y range 0..448: a simultaneous clamp leaves x one ahead of y.
  vga_bouncing_box #(.H_ACTIVE(481)) dut_c (
    .CLK_50(CLK_50), .RST_N(RST_N), .counter_x(counter_x), .counter_y(counter_y),
    .in_display_area(in_display_area), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .speed(speed), .pause(pause), .RED(red_c), .GREEN(green_c), .BLUE(blue_c),
    .h_sync(hs_c), .v_sync(vs_c), .frame_tick(ft_c), .bounce(bn_c)
  );

  task automatic step();
    @(posedge CLK_50);
    #1;
    if (ft_a) ticks++;
    if (bn_a) bc_a++;
    if (bn_b) bc_b++;
    if (bn_c) bc_c++;
  endtask

  // The tick registers one edge after counter_y reaches V_ACTIVE; motion lands one edge later.
  task automatic frame(input logic [3:0] spd);
    speed = spd;
    counter_y = 10'd0;
    step();
    counter_y = 10'd480;
    step();
    counter_y = 10'd0;
    step();
  endtask

  task automatic frames(input int n, input logic [3:0] spd);
    for (int i = 0; i < n; i++) frame(spd);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    counter_y = 10'd0;
    pause = 1'b0;
    speed = 4'd0;
    step();
    step();
    RST_N = 1'b1;
    ticks = 0;
    bc_a = 0;
    bc_b = 0;
    bc_c = 0;
  endtask

  task automatic test_reset();
    counter_x = 10'd100;
    counter_y = 10'd100;
    in_display_area = 1'b1;
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
    RST_N = 1'b0;
    step();
    tests_run++;
    if ({red_a, green_a, blue_a} !== 8'h00) begin
      tests_failed++; $display("FAIL reset_rgb: got %h expected 00", {red_a, green_a, blue_a});
    end
    tests_run++;
    if ({hs_a, vs_a, ft_a, bn_a} !== 4'b1100) begin
      tests_failed++; $display("FAIL reset_hs_vs_ft_bn: got %b expected 1100", {hs_a, vs_a, ft_a, bn_a});
    end
    tests_run++;
    if (dut.box_x !== 10'd100 || dut.box_y !== 10'd100 || dut.state !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_position: got x=%0d y=%0d st=%0d expected 100 100 0", dut.box_x, dut.box_y, dut.state);
    end
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    do_reset();
  endtask

  logic [9:0] px_cx [7] = '{10'd99, 10'd100, 10'd131, 10'd132, 10'd100, 10'd100, 10'd100};
  logic [9:0] px_cy [7] = '{10'd100, 10'd100, 10'd131, 10'd100, 10'd100, 10'd132, 10'd99};
  logic       px_de [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       px_hs [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       px_vs [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] px_exp [7] = '{8'h01, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h01};

  task automatic test_pixel();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      counter_x = px_cx[i];
      counter_y = px_cy[i];
      in_display_area = px_de[i];
      h_sync_in = px_hs[i];
      v_sync_in = px_vs[i];
      if (i > 0) begin
        #1;
        tests_run++;
        if ({red_a, green_a, blue_a, hs_a, vs_a} !== {px_exp[i-1], px_hs[i-1], px_vs[i-1]}) begin
          tests_failed++;
          $display("FAIL pixel_latency[%0d]: got %h expected %h", i,
                   {red_a, green_a, blue_a, hs_a, vs_a}, {px_exp[i-1], px_hs[i-1], px_vs[i-1]});
        end
      end
      step();
      tests_run++;
      if ({red_a, green_a, blue_a, hs_a, vs_a} !== {px_exp[i], px_hs[i], px_vs[i]}) begin
        tests_failed++;
        $display("FAIL pixel[%0d]: got %h expected %h", i,
                 {red_a, green_a, blue_a, hs_a, vs_a}, {px_exp[i], px_hs[i], px_vs[i]});
      end
    end
    in_display_area = 1'b0;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
  endtask

  task automatic test_one_frame();
    do_reset();
    frame(4'd2);
    tests_run++;
    if (dut.box_x !== 10'd102 || dut.box_y !== 10'd102 || dut.state !== 2'b00) begin
      tests_failed++;
      $display("FAIL one_frame_pos: got x=%0d y=%0d st=%0d expected 102 102 0", dut.box_x, dut.box_y, dut.state);
    end
    tests_run++;
    if (bc_a !== 0 || ticks !== 1) begin
      tests_failed++; $display("FAIL one_frame_counts: got bounces=%0d ticks=%0d expected 0 1", bc_a, ticks);
    end
  endtask

  task automatic test_right_wall();
    do_reset();
    frame(4'd5);
    tests_run++;
    if (dut_b.box_x !== 10'd608 || dut_b.box_y !== 10'd105 || dut_b.state !== 2'b10) begin
      tests_failed++;
      $display("FAIL right_wall_pos: got x=%0d y=%0d st=%0d expected 608 105 2", dut_b.box_x, dut_b.box_y, dut_b.state);
    end
    tests_run++;
    if (bn_b !== 1'b1 || bc_b !== 1) begin
      tests_failed++; $display("FAIL right_wall_bounce: got now=%b count=%0d expected 1 1", bn_b, bc_b);
    end
    frame(4'd0);
    tests_run++;
    if (dut_b.box_x !== 10'd608 || dut_b.box_y !== 10'd105 || dut_b.state !== 2'b10 || bc_b !== 1) begin
      tests_failed++;
      $display("FAIL speed_zero_at_wall: got x=%0d y=%0d st=%0d bounces=%0d expected 608 105 2 1",
               dut_b.box_x, dut_b.box_y, dut_b.state, bc_b);
    end
    frame(4'd5);
    tests_run++;
    if (dut_b.box_x !== 10'd603 || dut_b.box_y !== 10'd110 || bc_b !== 1) begin
      tests_failed++;
      $display("FAIL right_wall_next: got x=%0d y=%0d bounces=%0d expected 603 110 1", dut_b.box_x, dut_b.box_y, bc_b);
    end
  endtask

  task automatic test_corner();
    do_reset();
    frames(22, 4'd15);
    frame(4'd11);
    tests_run++;
    if (dut_c.box_x !== 10'd441 || dut_c.box_y !== 10'd441 || bc_c !== 0) begin
      tests_failed++;
      $display("FAIL corner_approach: got x=%0d y=%0d bounces=%0d expected 441 441 0", dut_c.box_x, dut_c.box_y, bc_c);
    end
    frame(4'd8);
    tests_run++;
    if (dut_c.box_x !== 10'd449 || dut_c.box_y !== 10'd448 || dut_c.state !== 2'b11 || bc_c !== 1) begin
      tests_failed++;
      $display("FAIL corner_bottom_right: got x=%0d y=%0d st=%0d bounces=%0d expected 449 448 3 1",
               dut_c.box_x, dut_c.box_y, dut_c.state, bc_c);
    end
    frames(29, 4'd15);
    frame(4'd11);
    tests_run++;
    if (dut_c.box_x !== 10'd3 || dut_c.box_y !== 10'd2 || dut_c.state !== 2'b11) begin
      tests_failed++;
      $display("FAIL corner_preload: got x=%0d y=%0d st=%0d expected 3 2 3", dut_c.box_x, dut_c.box_y, dut_c.state);
    end
    frame(4'd4);
    tests_run++;
    if (dut_c.box_x !== 10'd0 || dut_c.box_y !== 10'd0 || dut_c.state !== 2'b00 || bc_c !== 2) begin
      tests_failed++;
      $display("FAIL corner_top_left: got x=%0d y=%0d st=%0d bounces=%0d expected 0 0 0 2",
               dut_c.box_x, dut_c.box_y, dut_c.state, bc_c);
    end
  endtask

  task automatic test_pause();
    do_reset();
    pause = 1'b1;
    frames(3, 4'd3);
    tests_run++;
    if (ticks !== 3 || dut.box_x !== 10'd100 || dut.box_y !== 10'd100 || bc_a !== 0) begin
      tests_failed++;
      $display("FAIL pause: got ticks=%0d x=%0d y=%0d bounces=%0d expected 3 100 100 0", ticks, dut.box_x, dut.box_y, bc_a);
    end
    pause = 1'b0;
    counter_y = 10'd0;
    step();
    counter_y = 10'd480;
    for (int i = 0; i < 5; i++) step();
    counter_y = 10'd0;
    step();
    tests_run++;
    if (ticks !== 4 || dut.box_x !== 10'd103 || dut.box_y !== 10'd103) begin
      tests_failed++;
      $display("FAIL dwell_single_tick: got ticks=%0d x=%0d y=%0d expected 4 103 103", ticks, dut.box_x, dut.box_y);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    frame(4'd2);
    ticks = 0;
    speed = 4'd0;
    counter_y = 10'd0;
    step();
    counter_y = 10'd480;
    RST_N = 1'b0;
    step();
    tests_run++;
    if (dut.box_x !== 10'd100 || ft_a !== 1'b0) begin
      tests_failed++; $display("FAIL mid_frame_reset: got x=%0d tick=%b expected 100 0", dut.box_x, ft_a);
    end
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) step();
    tests_run++;
    if (ticks !== 0) begin
      tests_failed++; $display("FAIL no_tick_after_release: got %0d expected 0", ticks);
    end
    counter_y = 10'd0;
    step();
    counter_y = 10'd480;
    step();
    step();
    tests_run++;
    if (ticks !== 1) begin
      tests_failed++; $display("FAIL fresh_transition_tick: got %0d expected 1", ticks);
    end
    counter_y = 10'd0;
  endtask

  task automatic test_flash();
    logic [7:0] exp_col;
    do_reset();
    frame(4'd5);
    for (int k = 0; k < 8; k++) begin
      counter_x = 10'd608;
      counter_y = 10'd105;
      in_display_area = 1'b1;
      step();
`ifdef BOUNCE_FLASH_EN
      exp_col = (k < 7) ? 8'hE0 : 8'hFF;
`else
      exp_col = 8'hFF;
`endif
      tests_run++;
      if ({red_b, green_b, blue_b} !== exp_col) begin
        tests_failed++; $display("FAIL flash_frame[%0d]: got %h expected %h", k, {red_b, green_b, blue_b}, exp_col);
      end
      in_display_area = 1'b0;
      frame(4'd0);
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_one_frame();
    test_right_wall();
    test_corner();
    test_pause();
    test_reset_mid_frame();
    test_flash();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
